// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types and constants for the ECC operand loader
package ecc_pkg;

  localparam int ECC_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    START = 3'd3,
    BUSY  = 3'd4
  } state_t;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE      = 3'd0;
  localparam err_code_t ERR_BAD_PRIME = 3'd1;
  localparam err_code_t ERR_PX_RANGE  = 3'd2;
  localparam err_code_t ERR_PY_RANGE  = 3'd3;
  localparam err_code_t ERR_K_ZERO    = 3'd4;
  localparam err_code_t ERR_TIMEOUT   = 3'd5;

  localparam logic [2:0] FLD_A     = 3'd0;
  localparam logic [2:0] FLD_PRIME = 3'd1;
  localparam logic [2:0] FLD_PX    = 3'd2;
  localparam logic [2:0] FLD_PY    = 3'd3;
  localparam logic [2:0] FLD_K     = 3'd4;

endpackage

// File: rtl/ecc_operand_loader_if.sv
// rtl/ecc_operand_loader_if.sv - nibble stream, operand and multiplier handshake bundle
interface ecc_operand_loader_if #(
  parameter int SIZE = ecc_pkg::ECC_SIZE
);
  import ecc_pkg::*;

  logic            i_valid;
  logic [3:0]      i_nib;
  logic            o_ready;
  logic            i_abort;
  logic [SIZE-1:0] o_a;
  logic [SIZE-1:0] o_prime;
  logic [SIZE-1:0] o_px;
  logic [SIZE-1:0] o_py;
  logic [SIZE-1:0] o_k;
  logic            o_start;
  logic            i_done;
  logic            o_busy;
  logic            o_err;
  err_code_t       o_err_code;

  modport master (
    output i_valid, i_nib, i_abort, i_done,
    input  o_ready, o_a, o_prime, o_px, o_py, o_k,
    input  o_start, o_busy, o_err, o_err_code
  );

  modport slave (
    input  i_valid, i_nib, i_abort, i_done,
    output o_ready, o_a, o_prime, o_px, o_py, o_k,
    output o_start, o_busy, o_err, o_err_code
  );

endinterface

// File: rtl/ecc_operand_check.sv
// rtl/ecc_operand_check.sv - combinational range check of prime/Px/Py/k, lowest code wins
module ecc_operand_check
  import ecc_pkg::*;
#(
  parameter int SIZE = ECC_SIZE
) (
  input  logic [SIZE-1:0] prime,
  input  logic [SIZE-1:0] px,
  input  logic [SIZE-1:0] py,
  input  logic [SIZE-1:0] k,
  output err_code_t       err_code
);

  always_comb begin
    err_code = ERR_NONE;
    // An odd prime of 1 still fails: the field needs at least 3 elements.
    if (!prime[0] || (prime < SIZE'(3)))
      err_code = ERR_BAD_PRIME;
    else if (px >= prime)
      err_code = ERR_PX_RANGE;
    else if (py >= prime)
      err_code = ERR_PY_RANGE;
    else if (k == '0)
      err_code = ERR_K_ZERO;
  end

endmodule

// File: rtl/ecc_operand_loader.sv
// rtl/ecc_operand_loader.sv - nibble-serial operand loader; ECC_LOADER_TIMEOUT_EN adds a BUSY watchdog
module ecc_operand_loader
  import ecc_pkg::*;
#(
`ifdef ECC_LOADER_TIMEOUT_EN
  parameter int TIMEOUT = 4096,
`endif
  parameter int SIZE = ECC_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ecc_operand_loader_if.slave  bus
);

  localparam int NIBS = SIZE / 4;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   nib_cnt;
  logic [2:0]      field_idx;
  logic [SIZE-1:0] a_q, prime_q, px_q, py_q, k_q;
  logic            err_q;
  err_code_t       err_code_q;
  err_code_t       chk_code;
  logic            accept;
  logic            load_en;
  logic            nib_wrap;
  logic            last_nib;
  logic            tmo_hit;

  ecc_operand_check #(.SIZE(SIZE)) u_check (
    .prime    (prime_q),
    .px       (px_q),
    .py       (py_q),
    .k        (k_q),
    .err_code (chk_code)
  );

  assign accept   = bus.i_valid & bus.o_ready;
  // Abort in LOAD beats a same-cycle nibble so a discarded frame never leaks into the next.
  assign load_en  = accept & ((state == IDLE) | ((state == LOAD) & ~bus.i_abort));
  assign nib_wrap = (nib_cnt == CW'(NIBS - 1));
  assign last_nib = nib_wrap & (field_idx == FLD_K);

`ifdef ECC_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      tmo_cnt <= '0;
    else if (state == BUSY)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  assign tmo_hit = (state == BUSY) & (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = LOAD;
      LOAD: begin
        if (bus.i_abort)
          state_nxt = IDLE;
        else if (accept && last_nib)
          state_nxt = CHECK;
      end
      CHECK: state_nxt = (chk_code != ERR_NONE) ? IDLE : START;
      START: state_nxt = BUSY;
      BUSY:  if (bus.i_done || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state == IDLE) | (state == LOAD);
    bus.o_start = (state == START);
    bus.o_busy  = (state == START) | (state == BUSY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nib_cnt    <= '0;
      field_idx  <= FLD_A;
      a_q        <= '0;
      prime_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      k_q        <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (load_en) begin
        case (field_idx)
          FLD_A:     a_q     <= {a_q[SIZE-5:0], bus.i_nib};
          FLD_PRIME: prime_q <= {prime_q[SIZE-5:0], bus.i_nib};
          FLD_PX:    px_q    <= {px_q[SIZE-5:0], bus.i_nib};
          FLD_PY:    py_q    <= {py_q[SIZE-5:0], bus.i_nib};
          default:   k_q     <= {k_q[SIZE-5:0], bus.i_nib};
        endcase
        if (nib_wrap) begin
          nib_cnt   <= '0;
          field_idx <= last_nib ? FLD_A : field_idx + 3'd1;
        end else begin
          nib_cnt <= nib_cnt + 1'b1;
        end
      end

      if ((state == IDLE) && accept) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end

      if ((state == LOAD) && bus.i_abort) begin
        nib_cnt   <= '0;
        field_idx <= FLD_A;
      end

      if ((state == CHECK) && (chk_code != ERR_NONE)) begin
        err_q      <= 1'b1;
        err_code_q <= chk_code;
      end

      // A done arriving in the watchdog's final cycle still counts as success.
      if (tmo_hit && !bus.i_done) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end
    end
  end

  assign bus.o_a        = a_q;
  assign bus.o_prime    = prime_q;
  assign bus.o_px       = px_q;
  assign bus.o_py       = py_q;
  assign bus.o_k        = k_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;

endmodule
